// File: rtl/pipeline_controller_pkg.sv
// Shared types and defaults for the pipeline controller: per-stage control word,
// recovery phase enum and the stage index map used to build the control vectors.
package pipeline_controller_pkg;

   typedef struct packed {
      logic stall;
      logic clear;
   } PipelineControll;

   typedef enum logic {
      CP_RUN,
      CP_RECOVER
   } ControllerPhase;

   localparam int CONTROLLER_RECOVERY_CYCLES     = 2;
   localparam int CONTROLLER_EMPTY_SETTLE_CYCLES = 2;

   // Bit positions of each stage inside the internal stall/clear vectors.
   localparam int STG_NP = 0;
   localparam int STG_IF = 1;
   localparam int STG_PD = 2;
   localparam int STG_ID = 3;
   localparam int STG_RN = 4;
   localparam int STG_DS = 5;
   localparam int STG_SC = 6;
   localparam int STG_IS = 7;
   localparam int STG_BE = 8;
   localparam int STG_CM = 9;
   localparam int NUM_STAGES = 10;

endpackage

// File: rtl/pipeline_empty_detector.sv
// Settles the raw all-empty condition: the flag rises only after SETTLE consecutive
// empty cycles and drops the cycle after any non-empty cycle.
module pipeline_empty_detector #(
   parameter int SETTLE = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic allEmpty_i,
   output logic wholePipelineEmpty_o
);

   localparam int SCW = $clog2(SETTLE + 1);

   logic [SCW-1:0] settleCnt_q, settleCnt_d;
   logic           flag_q, flag_d;

   // Counter saturates at SETTLE so a long idle period never wraps back to zero.
   always_comb begin
      settleCnt_d = '0;
      flag_d      = 1'b0;
      if (allEmpty_i) begin
         settleCnt_d = (settleCnt_q == SCW'(SETTLE)) ? settleCnt_q : settleCnt_q + 1'b1;
         flag_d      = (settleCnt_d == SCW'(SETTLE));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         settleCnt_q <= '0;
         flag_q      <= 1'b0;
      end else begin
         settleCnt_q <= settleCnt_d;
         flag_q      <= flag_d;
      end
   end

   assign wholePipelineEmpty_o = flag_q;

endmodule

// File: rtl/pipeline_controller.sv
// Collects stall/flush/bubble requests from the stages and produces one {stall, clear}
// pair per stage, plus the post-commit-flush recovery FSM and the settled empty flag.
module pipeline_controller
   import pipeline_controller_pkg::*;
#(
   parameter int RECOVERY_CYCLES     = CONTROLLER_RECOVERY_CYCLES,
   parameter int EMPTY_SETTLE_CYCLES = CONTROLLER_EMPTY_SETTLE_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmStageFlushUpper,
   input  logic       rnStageFlushUpper,
   input  logic       rnStageSendBubbleLower,
   input  logic       idStageStallUpper,
   input  logic       ifStageSendBubbleLower,
   input  logic       npStageSendBubbleLower,
   input  logic       npStageSendBubbleLowerForInterrupt,
   input  logic       isStageStallUpper,
   input  logic       ifStageEmpty,
   input  logic       pdStageEmpty,
   input  logic       idStageEmpty,
   input  logic       rnStageEmpty,
   input  logic       activeListEmpty,
   output logic [1:0] npStage,
   output logic [1:0] ifStage,
   output logic [1:0] pdStage,
   output logic [1:0] idStage,
   output logic [1:0] rnStage,
   output logic [1:0] dsStage,
   output logic [1:0] scStage,
   output logic [1:0] isStage,
   output logic [1:0] backEnd,
   output logic [1:0] cmStage,
   output logic       stallByDecodeStage,
   output logic       wholePipelineEmpty
);

   localparam int RCW = (RECOVERY_CYCLES > 0) ? $clog2(RECOVERY_CYCLES + 1) : 1;
   localparam logic [RCW-1:0] RECOVER_RELOAD = RCW'(RECOVERY_CYCLES);

   ControllerPhase  phase_q;
   logic [RCW-1:0]  recoverCnt_q;
   logic [NUM_STAGES-1:0] stallReq, clearReq, stallOut;
   logic            allEmpty;

   // A flush arriving during recovery restarts the full NOP window.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q      <= CP_RUN;
         recoverCnt_q <= '0;
      end else if (cmStageFlushUpper) begin
         if (RECOVERY_CYCLES > 0) begin
            phase_q      <= CP_RECOVER;
            recoverCnt_q <= RECOVER_RELOAD;
         end else begin
            phase_q      <= CP_RUN;
            recoverCnt_q <= '0;
         end
      end else if (phase_q == CP_RECOVER) begin
         recoverCnt_q <= recoverCnt_q - 1'b1;
         if (recoverCnt_q <= RCW'(1)) begin
            phase_q <= CP_RUN;
         end
      end
   end

   always_comb begin
      stallReq           = '0;
      clearReq           = '0;
      stallByDecodeStage = 1'b0;
      if (rst || cmStageFlushUpper) begin
         clearReq = '1;
      end else begin
         if (phase_q == CP_RECOVER) begin
            clearReq[STG_RN:STG_NP] = '1;
         end
         if (rnStageFlushUpper) begin
            clearReq[STG_ID:STG_NP] = '1;
         end
         if (rnStageSendBubbleLower) begin
            clearReq[STG_RN]        = 1'b1;
            stallReq[STG_ID:STG_NP] = '1;
         end
         if (idStageStallUpper) begin
            stallReq[STG_PD:STG_NP] = '1;
            stallByDecodeStage = (phase_q == CP_RUN) && !rnStageFlushUpper &&
                                 !rnStageSendBubbleLower;
         end
         if (isStageStallUpper) begin
            stallReq[STG_SC] = 1'b1;
            stallReq[STG_IS] = 1'b1;
            clearReq[STG_IS] = 1'b1;
         end
         if (ifStageSendBubbleLower) begin
            clearReq[STG_IF] = 1'b1;
            stallReq[STG_NP] = 1'b1;
         end
         if (npStageSendBubbleLower || npStageSendBubbleLowerForInterrupt) begin
            clearReq[STG_NP] = 1'b1;
         end
      end
   end

   // A cleared stage carries a NOP, so holding it as well would be meaningless.
   assign stallOut = stallReq & ~clearReq;

   assign npStage = {stallOut[STG_NP], clearReq[STG_NP]};
   assign ifStage = {stallOut[STG_IF], clearReq[STG_IF]};
   assign pdStage = {stallOut[STG_PD], clearReq[STG_PD]};
   assign idStage = {stallOut[STG_ID], clearReq[STG_ID]};
   assign rnStage = {stallOut[STG_RN], clearReq[STG_RN]};
   assign dsStage = {stallOut[STG_DS], clearReq[STG_DS]};
   assign scStage = {stallOut[STG_SC], clearReq[STG_SC]};
   assign isStage = {stallOut[STG_IS], clearReq[STG_IS]};
   assign backEnd = {stallOut[STG_BE], clearReq[STG_BE]};
   assign cmStage = {stallOut[STG_CM], clearReq[STG_CM]};

   assign allEmpty = ifStageEmpty && pdStageEmpty && idStageEmpty && rnStageEmpty &&
                     activeListEmpty && (phase_q == CP_RUN) && !cmStageFlushUpper;

   pipeline_empty_detector #(
      .SETTLE(EMPTY_SETTLE_CYCLES)
   ) emptyDetector (
      .clk                  (clk),
      .rst                  (rst),
      .allEmpty_i           (allEmpty),
      .wholePipelineEmpty_o (wholePipelineEmpty)
   );

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed scoreboard bench for pipeline_controller: each stimulus cycle queues its
// hand-computed control vectors, a negedge monitor pops and compares them.
module tb_pipeline_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cmStageFlushUpper, rnStageFlushUpper, rnStageSendBubbleLower, idStageStallUpper;
   logic ifStageSendBubbleLower, npStageSendBubbleLower, npStageSendBubbleLowerForInterrupt;
   logic isStageStallUpper;
   logic ifStageEmpty, pdStageEmpty, idStageEmpty, rnStageEmpty, activeListEmpty;
   logic [1:0] npStage, ifStage, pdStage, idStage, rnStage;
   logic [1:0] dsStage, scStage, isStage, backEnd, cmStage;
   logic stallByDecodeStage, wholePipelineEmpty;
   logic [9:0] dutStall, dutClear;

   always #5 clk = ~clk;

   pipeline_controller dut (
      .clk                                (clk),
      .rst                                (rst),
      .cmStageFlushUpper                  (cmStageFlushUpper),
      .rnStageFlushUpper                  (rnStageFlushUpper),
      .rnStageSendBubbleLower             (rnStageSendBubbleLower),
      .idStageStallUpper                  (idStageStallUpper),
      .ifStageSendBubbleLower             (ifStageSendBubbleLower),
      .npStageSendBubbleLower             (npStageSendBubbleLower),
      .npStageSendBubbleLowerForInterrupt (npStageSendBubbleLowerForInterrupt),
      .isStageStallUpper                  (isStageStallUpper),
      .ifStageEmpty                       (ifStageEmpty),
      .pdStageEmpty                       (pdStageEmpty),
      .idStageEmpty                       (idStageEmpty),
      .rnStageEmpty                       (rnStageEmpty),
      .activeListEmpty                    (activeListEmpty),
      .npStage                            (npStage),
      .ifStage                            (ifStage),
      .pdStage                            (pdStage),
      .idStage                            (idStage),
      .rnStage                            (rnStage),
      .dsStage                            (dsStage),
      .scStage                            (scStage),
      .isStage                            (isStage),
      .backEnd                            (backEnd),
      .cmStage                            (cmStage),
      .stallByDecodeStage                 (stallByDecodeStage),
      .wholePipelineEmpty                 (wholePipelineEmpty)
   );

   // Vector bit order: 0=np 1=if 2=pd 3=id 4=rn 5=ds 6=sc 7=is 8=backEnd 9=cm
   assign dutStall = {cmStage[1], backEnd[1], isStage[1], scStage[1], dsStage[1],
                      rnStage[1], idStage[1], pdStage[1], ifStage[1], npStage[1]};
   assign dutClear = {cmStage[0], backEnd[0], isStage[0], scStage[0], dsStage[0],
                      rnStage[0], idStage[0], pdStage[0], ifStage[0], npStage[0]};

   localparam logic [12:0] I_CM  = 13'h1000;
   localparam logic [12:0] I_RNF = 13'h0800;
   localparam logic [12:0] I_RNB = 13'h0400;
   localparam logic [12:0] I_IDS = 13'h0200;
   localparam logic [12:0] I_IFB = 13'h0100;
   localparam logic [12:0] I_NPB = 13'h0080;
   localparam logic [12:0] I_NPI = 13'h0040;
   localparam logic [12:0] I_ISS = 13'h0020;
   localparam logic [12:0] E_ALL = 13'h001F;
   localparam logic [12:0] E_NOAL = 13'h001E;
   localparam logic [12:0] E_NOPD = 13'h0017;

   localparam logic [9:0] V_ALL   = 10'h3FF;
   localparam logic [9:0] V_FRONT = 10'h01F;
   localparam logic [9:0] V_NONE  = 10'h000;

   typedef struct {
      string      name;
      logic [9:0] stall;
      logic [9:0] clear;
      logic       sbd;
      logic       wpe;
   } expEntry_t;

   expEntry_t expQ[$];
   int assertCount = 0;
   int failCount   = 0;
   bit stimDone    = 1'b0;

   task automatic checkOutput(input string name, input logic [9:0] actual,
                              input logic [9:0] required);
      assertCount++;
      if (actual !== required) begin
         failCount++;
         $display("[TB] FAIL %s: got %b required %b", name, actual, required);
      end
   endtask

   task automatic applyStimulus(input string name, input logic r, input logic [12:0] in,
                                input logic [9:0] expStall, input logic [9:0] expClear,
                                input logic sbd, input logic wpe);
      expEntry_t e;
      @(posedge clk);
      #1;
      rst = r;
      {cmStageFlushUpper, rnStageFlushUpper, rnStageSendBubbleLower, idStageStallUpper,
       ifStageSendBubbleLower, npStageSendBubbleLower, npStageSendBubbleLowerForInterrupt,
       isStageStallUpper, ifStageEmpty, pdStageEmpty, idStageEmpty, rnStageEmpty,
       activeListEmpty} = in;
      e.name  = name;
      e.stall = expStall;
      e.clear = expClear;
      e.sbd   = sbd;
      e.wpe   = wpe;
      expQ.push_back(e);
   endtask

   initial begin : monitor
      expEntry_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({e.name, ".stall"}, dutStall, e.stall);
            checkOutput({e.name, ".clear"}, dutClear, e.clear);
            checkOutput({e.name, ".sbd"}, {9'b0, stallByDecodeStage}, {9'b0, e.sbd});
            checkOutput({e.name, ".wpe"}, {9'b0, wholePipelineEmpty}, {9'b0, e.wpe});
         end
      end
   end

   initial begin : watchdog
      #50000;
      $display("[TB] FAIL watchdog: stimulus not finished, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      {cmStageFlushUpper, rnStageFlushUpper, rnStageSendBubbleLower, idStageStallUpper,
       ifStageSendBubbleLower, npStageSendBubbleLower, npStageSendBubbleLowerForInterrupt,
       isStageStallUpper, ifStageEmpty, pdStageEmpty, idStageEmpty, rnStageEmpty,
       activeListEmpty} = E_ALL;
      rst = 1'b1;

      applyStimulus("rst0", 1'b1, E_ALL, V_NONE, V_ALL, 1'b0, 1'b0);
      applyStimulus("rst1", 1'b1, E_ALL, V_NONE, V_ALL, 1'b0, 1'b0);
      applyStimulus("rst2", 1'b1, E_ALL, V_NONE, V_ALL, 1'b0, 1'b0);
      applyStimulus("idle0", 1'b0, E_ALL, V_NONE, V_NONE, 1'b0, 1'b0);
      applyStimulus("idle1", 1'b0, E_ALL, V_NONE, V_NONE, 1'b0, 1'b0);
      applyStimulus("idle2", 1'b0, E_ALL, V_NONE, V_NONE, 1'b0, 1'b1);
      applyStimulus("idle3", 1'b0, E_ALL, V_NONE, V_NONE, 1'b0, 1'b1);

      applyStimulus("cmFlushIdStall", 1'b0, E_ALL | I_CM | I_IDS, V_NONE, V_ALL, 1'b0, 1'b1);
      applyStimulus("recover1", 1'b0, E_ALL | I_IDS, V_NONE, V_FRONT, 1'b0, 1'b0);
      applyStimulus("recover2", 1'b0, E_ALL | I_IDS, V_NONE, V_FRONT, 1'b0, 1'b0);
      applyStimulus("runIdStall", 1'b0, E_ALL | I_IDS, 10'h007, V_NONE, 1'b1, 1'b0);

      applyStimulus("cmFlushA", 1'b0, E_ALL | I_CM, V_NONE, V_ALL, 1'b0, 1'b0);
      applyStimulus("cmFlushInRecover", 1'b0, E_ALL | I_CM, V_NONE, V_ALL, 1'b0, 1'b0);
      applyStimulus("reRecover1", 1'b0, E_ALL, V_NONE, V_FRONT, 1'b0, 1'b0);
      applyStimulus("reRecover2", 1'b0, E_ALL, V_NONE, V_FRONT, 1'b0, 1'b0);
      applyStimulus("backToRun", 1'b0, E_ALL, V_NONE, V_NONE, 1'b0, 1'b0);

      applyStimulus("rnBubbleIsStall", 1'b0, E_ALL | I_RNB | I_ISS, 10'h04F, 10'h090, 1'b0, 1'b0);
      applyStimulus("rnBubbleIdStall", 1'b0, E_ALL | I_RNB | I_IDS, 10'h00F, 10'h010, 1'b0, 1'b1);
      applyStimulus("ifBubbleNpInt", 1'b0, E_ALL | I_IFB | I_NPI, V_NONE, 10'h003, 1'b0, 1'b1);
      applyStimulus("rnFlushIdStallNpB", 1'b0, E_ALL | I_RNF | I_IDS | I_NPB, V_NONE, 10'h00F,
                    1'b0, 1'b1);
      applyStimulus("ifBubble", 1'b0, E_ALL | I_IFB, 10'h001, 10'h002, 1'b0, 1'b1);
      applyStimulus("isStall", 1'b0, E_ALL | I_ISS, 10'h040, 10'h080, 1'b0, 1'b1);

      applyStimulus("empty0", 1'b0, E_ALL, V_NONE, V_NONE, 1'b0, 1'b1);
      applyStimulus("alBusy", 1'b0, E_NOAL, V_NONE, V_NONE, 1'b0, 1'b1);
      applyStimulus("emptyOnce", 1'b0, E_ALL, V_NONE, V_NONE, 1'b0, 1'b0);
      applyStimulus("pdBusy", 1'b0, E_NOPD, V_NONE, V_NONE, 1'b0, 1'b0);
      applyStimulus("settleA", 1'b0, E_ALL, V_NONE, V_NONE, 1'b0, 1'b0);
      applyStimulus("settleB", 1'b0, E_ALL, V_NONE, V_NONE, 1'b0, 1'b0);
      applyStimulus("settled", 1'b0, E_ALL, V_NONE, V_NONE, 1'b0, 1'b1);
      applyStimulus("rstWhileFlag", 1'b1, E_ALL, V_NONE, V_ALL, 1'b0, 1'b1);
      applyStimulus("rstFlagDrop", 1'b1, E_ALL, V_NONE, V_ALL, 1'b0, 1'b0);
      applyStimulus("afterRst", 1'b0, E_ALL, V_NONE, V_NONE, 1'b0, 1'b0);

      applyStimulus("cmFlushB", 1'b0, E_ALL | I_CM, V_NONE, V_ALL, 1'b0, 1'b0);
      applyStimulus("rstInRecover", 1'b1, E_ALL, V_NONE, V_ALL, 1'b0, 1'b0);
      applyStimulus("runAfterRst", 1'b0, E_ALL, V_NONE, V_NONE, 1'b0, 1'b0);

      @(posedge clk);
      @(posedge clk);
      stimDone = 1'b1;
   end

   initial begin : finisher
      wait (stimDone);
      assertCount++;
      if (expQ.size() != 0) begin
         failCount++;
         $display("[TB] FAIL queueDrain: got %0d pending required 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
